// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared helpers for the radix-2 FFT butterfly datapath
// Contents:
//   TW_INT_BITS    integer bits of the Q2.(H-2) twiddle format
//   tw_frac_bits   fraction bits of a twiddle for half-word width h
//   cpx_re/cpx_im  sign-extended real/imag field of a complex word
//   tw_val         elaboration-time twiddle ROM entry {re[63:32], im[31:0]}
package fft_pkg;

  localparam int TW_INT_BITS = 2;

  function automatic int tw_frac_bits(input int h);
    return h - TW_INT_BITS;
  endfunction

  // Real part sits in the upper half of the word.
  function automatic logic signed [31:0] cpx_re(input logic [63:0] w, input int ws);
    logic signed [63:0] t;
    t = signed'(w << (64 - ws));
    return 32'(t >>> (64 - ws / 2));
  endfunction

  function automatic logic signed [31:0] cpx_im(input logic [63:0] w, input int ws);
    logic signed [63:0] t;
    t = signed'(w << (64 - ws / 2));
    return 32'(t >>> (64 - ws / 2));
  endfunction

  // Taylor series, only ever evaluated on [0, pi/2).
  function automatic real tw_sin(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int i = 1; i < 12; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic real tw_cos(input real x);
    real term;
    real sum;
    term = 1.0;
    sum  = 1.0;
    for (int i = 1; i < 12; i++) begin
      term = -term * x * x / real'((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic int tw_round_pos(input real x);
    return $rtoi(x + 0.5);
  endfunction

  // W_k = exp(-j*2*pi*k/n). The angle is folded into the first quadrant so
  // quadrant boundaries (0, +-1) come out exact rather than from a series.
  function automatic logic [63:0] tw_val(input int k, input int n, input int h);
    int  q;
    int  m;
    int  one;
    int  ci;
    int  si;
    int  w_re;
    int  w_im;
    real th;
    q   = k / (n / 4);
    m   = k % (n / 4);
    th  = 6.283185307179586 * real'(m) / real'(n);
    one = 1 << tw_frac_bits(h);
    ci  = tw_round_pos(tw_cos(th) * real'(one));
    si  = tw_round_pos(tw_sin(th) * real'(one));
    case (q)
      0:       begin w_re = ci;  w_im = -si; end
      1:       begin w_re = -si; w_im = -ci; end
      2:       begin w_re = -ci; w_im = si;  end
      default: begin w_re = si;  w_im = ci;  end
    endcase
    return {w_re, w_im};
  endfunction

endpackage

// File: rtl/butterfly_r2_pipe_if.sv
// rtl/butterfly_r2_pipe_if.sv - operand/result handshake bundle of the butterfly
// master: drives operands (in_valid, num1, num2, twiddle_index, inverse, scale)
//         and out_ready; slave: drives in_ready, out_valid, result1, result2.
interface butterfly_r2_pipe_if #(
  parameter int N         = 8,
  parameter int WORD_SIZE = 32
);
  localparam int TW_IDX_SIZE = $clog2(N);

  logic                   in_valid;
  logic                   in_ready;
  logic [WORD_SIZE-1:0]   num1;
  logic [WORD_SIZE-1:0]   num2;
  logic [TW_IDX_SIZE-1:0] twiddle_index;
  logic                   inverse;
  logic                   scale;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_SIZE-1:0]   result1;
  logic [WORD_SIZE-1:0]   result2;

  modport master (
    output in_valid, num1, num2, twiddle_index, inverse, scale, out_ready,
    input  in_ready, out_valid, result1, result2
  );

  modport slave (
    input  in_valid, num1, num2, twiddle_index, inverse, scale, out_ready,
    output in_ready, out_valid, result1, result2
  );
endinterface

// File: rtl/twiddle_rom.sv
// rtl/twiddle_rom.sv - registered twiddle lookup with optional conjugation
// Ports: clk, rst (sync, active-high), en (advance), idx (k), inverse
//        (conjugate W), wr/wi (registered Q2.(H-2) twiddle parts).
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int N         = 8,
  parameter int WORD_SIZE = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [$clog2(N)-1:0]         idx,
  input  logic                         inverse,
  output logic signed [WORD_SIZE/2-1:0] wr,
  output logic signed [WORD_SIZE/2-1:0] wi
);
  localparam int H = WORD_SIZE / 2;

  logic signed [H-1:0] rom_re [N];
  logic signed [H-1:0] rom_im [N];

  for (genvar i = 0; i < N; i++) begin : g_rom
    localparam logic [63:0] ENTRY = tw_val(i, N, H);
    assign rom_re[i] = ENTRY[32 +: H];
    assign rom_im[i] = ENTRY[0 +: H];
  end

  // |imag| <= 1.0 in Q2.(H-2), so negation never overflows H bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      wi <= '0;
    end else if (en) begin
      wr <= rom_re[idx];
      wi <= inverse ? -rom_im[idx] : rom_im[idx];
    end
  end
endmodule

// File: rtl/butterfly_r2_pipe.sv
// rtl/butterfly_r2_pipe.sv - 3-stage radix-2 DIT butterfly, result1 = a + W*b, result2 = a - W*b
// Ports: clk, rst (sync, active-high), bus (butterfly_r2_pipe_if.slave),
//        sat_flag (sticky clip indicator, only when BFLY_SAT_EN is defined).
// Build option BFLY_SAT_EN: saturate instead of wrap on the final narrowing.
module butterfly_r2_pipe
  import fft_pkg::*;
#(
  parameter int N         = 8,
  parameter int WORD_SIZE = 32
) (
  input logic                clk,
  input logic                rst,
  butterfly_r2_pipe_if.slave bus
`ifdef BFLY_SAT_EN
  ,
  output logic               sat_flag
`endif
);
  localparam int H  = WORD_SIZE / 2;
  localparam int FB = tw_frac_bits(H);
  localparam int PW = 2 * H;
  localparam int SW = H + 2;
  localparam logic signed [PW-1:0] PROD_RND = PW'(1) <<< (FB - 1);

  // Global stall: every stage advances together or not at all.
  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // S1: operands, scale and the looked-up twiddle.
  logic                v1;
  logic                sc1;
  logic signed [H-1:0] ar1, ai1, br1, bi1;
  logic signed [H-1:0] wr1, wi1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      sc1 <= 1'b0;
      ar1 <= '0;
      ai1 <= '0;
      br1 <= '0;
      bi1 <= '0;
    end else if (adv) begin
      v1  <= bus.in_valid;
      sc1 <= bus.scale;
      ar1 <= H'(cpx_re(64'(bus.num1), WORD_SIZE));
      ai1 <= H'(cpx_im(64'(bus.num1), WORD_SIZE));
      br1 <= H'(cpx_re(64'(bus.num2), WORD_SIZE));
      bi1 <= H'(cpx_im(64'(bus.num2), WORD_SIZE));
    end
  end

  // inverse is consumed here: the ROM register holds the conjugated twiddle.
  twiddle_rom #(.N(N), .WORD_SIZE(WORD_SIZE)) u_rom (
    .clk    (clk),
    .rst    (rst),
    .en     (adv),
    .idx    (bus.twiddle_index),
    .inverse(bus.inverse),
    .wr     (wr1),
    .wi     (wi1)
  );

  // S2: full-precision W*b. |W| <= 1.0 keeps each sum of products in PW bits.
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  always_comb begin
    p_rr = PW'(br1) * PW'(wr1);
    p_ii = PW'(bi1) * PW'(wi1);
    p_ri = PW'(br1) * PW'(wi1);
    p_ir = PW'(bi1) * PW'(wr1);
  end

  logic                 v2;
  logic                 sc2;
  logic signed [H-1:0]  ar2, ai2;
  logic signed [PW-1:0] wb_re2, wb_im2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2     <= 1'b0;
      sc2    <= 1'b0;
      ar2    <= '0;
      ai2    <= '0;
      wb_re2 <= '0;
      wb_im2 <= '0;
    end else if (adv) begin
      v2     <= v1;
      sc2    <= sc1;
      ar2    <= ar1;
      ai2    <= ai1;
      wb_re2 <= p_rr - p_ii;
      wb_im2 <= p_ri + p_ir;
    end
  end

  // S3 helpers.
  function automatic logic signed [SW-1:0] scl(input logic signed [SW-1:0] x, input logic s);
    logic signed [SW-1:0] t;
    t = x + SW'(1);
    return s ? (t >>> 1) : x;
  endfunction

`ifdef BFLY_SAT_EN
  function automatic logic fits(input logic signed [SW-1:0] x);
    return x == SW'(signed'(x[H-1:0]));
  endfunction
`endif

  function automatic logic [H-1:0] nrw(input logic signed [SW-1:0] x);
`ifdef BFLY_SAT_EN
    if (!fits(x)) begin
      return x[SW-1] ? {1'b1, {(H-1){1'b0}}} : {1'b0, {(H-1){1'b1}}};
    end
`endif
    return x[H-1:0];
  endfunction

  // S3: round W*b back to H+2 bits, form a +- W*b, scale, narrow.
  logic signed [SW-1:0] wbr, wbi, ae_r, ae_i;
  logic signed [SW-1:0] s1r, s1i, s2r, s2i;
  always_comb begin
    wbr  = SW'((wb_re2 + PROD_RND) >>> FB);
    wbi  = SW'((wb_im2 + PROD_RND) >>> FB);
    ae_r = SW'(ar2);
    ae_i = SW'(ai2);
    s1r  = scl(ae_r + wbr, sc2);
    s1i  = scl(ae_i + wbi, sc2);
    s2r  = scl(ae_r - wbr, sc2);
    s2i  = scl(ae_i - wbi, sc2);
  end

  logic                 v3;
  logic [WORD_SIZE-1:0] r1_q, r2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v3   <= 1'b0;
      r1_q <= '0;
      r2_q <= '0;
    end else if (adv) begin
      v3   <= v2;
      r1_q <= {nrw(s1r), nrw(s1i)};
      r2_q <= {nrw(s2r), nrw(s2i)};
    end
  end

  assign bus.out_valid = v3;
  assign bus.result1   = r1_q;
  assign bus.result2   = r2_q;

`ifdef BFLY_SAT_EN
  logic any_clip;
  assign any_clip = !fits(s1r) || !fits(s1i) || !fits(s2r) || !fits(s2i);

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (adv && v2 && any_clip) begin
      sat_flag <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// tb/tb_butterfly_r2_pipe.sv - self-checking bench for butterfly_r2_pipe (N=8, WORD_SIZE=32)
module tb_butterfly_r2_pipe;
  localparam int N         = 8;
  localparam int WORD_SIZE = 32;
  localparam real PI       = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  butterfly_r2_pipe_if #(.N(N), .WORD_SIZE(WORD_SIZE)) bus ();

`ifdef BFLY_SAT_EN
  logic sat_flag;
`endif

  butterfly_r2_pipe #(.N(N), .WORD_SIZE(WORD_SIZE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef BFLY_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    bit          clip;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_err;
  bit   sat_model;

  function automatic logic [31:0] pack(input int re, input int im);
    logic [31:0] r;
    r = {re[15:0], im[15:0]};
    return r;
  endfunction

  function automatic longint fdiv(input longint x, input longint d);
    return (x >= 0) ? x / d : -((-x + d - 1) / d);
  endfunction

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($floor(x + 0.5));
    return -longint'($floor(-x + 0.5));
  endfunction

  function automatic logic [15:0] narrow(input longint v, inout bit clip);
`ifdef BFLY_SAT_EN
    if (v > 32767) begin clip = 1'b1; return 16'h7fff; end
    if (v < -32768) begin clip = 1'b1; return 16'h8000; end
`endif
    return v[15:0];
  endfunction

  // Reference: W from cos/sin, exact integer arithmetic, floor-based rounding.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input int k, input bit inv, input bit sc);
    exp_t   e;
    real    ang;
    longint wr, wi, ar, ai, br, bi, pr, pi;
    longint s [4];
    ang = 2.0 * PI * real'(k) / real'(N);
    wr  = rnd($cos(ang) * 16384.0);
    wi  = rnd(-$sin(ang) * 16384.0);
    if (inv) wi = -wi;
    ar = $signed(a[31:16]);
    ai = $signed(a[15:0]);
    br = $signed(b[31:16]);
    bi = $signed(b[15:0]);
    pr = fdiv(br * wr - bi * wi + 8192, 16384);
    pi = fdiv(br * wi + bi * wr + 8192, 16384);
    s[0] = ar + pr;
    s[1] = ai + pi;
    s[2] = ar - pr;
    s[3] = ai - pi;
    if (sc) for (int i = 0; i < 4; i++) s[i] = fdiv(s[i] + 1, 2);
    e.clip = 1'b0;
    e.r1 = {narrow(s[0], e.clip), narrow(s[1], e.clip)};
    e.r2 = {narrow(s[2], e.clip), narrow(s[3], e.clip)};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Handshakes are judged at the negedge, then time moves to just after the next posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst && bus.in_valid && bus.in_ready) begin
      e = model(bus.num1, bus.num2, int'(bus.twiddle_index), bus.inverse, bus.scale);
      sat_model = sat_model | e.clip;
      q.push_back(e);
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      chk("output_expected", 64'(q.size() != 0), 64'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_result1", bus.result1, e.r1);
        chk("sb_result2", bus.result2, e.r2);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input int k,
                      input bit inv, input bit sc);
    bus.in_valid      = 1'b1;
    bus.num1          = a;
    bus.num2          = b;
    bus.twiddle_index = 3'(k);
    bus.inverse       = inv;
    bus.scale         = sc;
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int k, input bit inv, input bit sc,
                         input logic [31:0] x1, input logic [31:0] x2);
    send(a, b, k, inv, sc);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_valid_t1"}, bus.out_valid, 0);
    tick();
    chk({tag, "_valid_t2"}, bus.out_valid, 0);
    tick();
    chk({tag, "_valid_t3"}, bus.out_valid, 1);
    chk({tag, "_result1"}, bus.result1, x1);
    chk({tag, "_result2"}, bus.result2, x2);
    tick();
  endtask

  task automatic drain(input string tag);
    int cnt;
    cnt = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (q.size() != 0 && cnt < 50) begin
      tick();
      cnt++;
    end
    chk({tag, "_pending"}, q.size(), 0);
    chk({tag, "_idle_valid"}, bus.out_valid, 0);
  endtask

  function automatic logic [31:0] mid_val();
    return pack(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000);
  endfunction

  initial begin
    int wait_cnt;
    n_cmp = 0;
    n_err = 0;
    sat_model = 1'b0;
    bus.in_valid = 1'b0;
    bus.num1 = '0;
    bus.num2 = '0;
    bus.twiddle_index = '0;
    bus.inverse = 1'b0;
    bus.scale = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result1", bus.result1, 0);
    chk("rst_result2", bus.result2, 0);
    chk("rst_in_ready", bus.in_ready, 1);
`ifdef BFLY_SAT_EN
    chk("rst_sat_flag", sat_flag, 0);
`endif
    rst = 1'b0;

    run_one("t1_k0", pack(100, 0), pack(50, 0), 0, 0, 0, pack(150, 0), pack(50, 0));
    run_one("t2_k2", pack(100, 0), pack(64, 0), 2, 0, 0, pack(100, -64), pack(100, 64));
    run_one("t2_k2_inv", pack(100, 0), pack(64, 0), 2, 1, 0, pack(100, 64), pack(100, -64));
    run_one("t3_scale", pack(100, 0), pack(50, 0), 0, 0, 1, pack(75, 0), pack(25, 0));
    run_one("k5_w135", pack(1000, -300), pack(400, 700), 5, 0, 0,
            model(pack(1000, -300), pack(400, 700), 5, 0, 0).r1,
            model(pack(1000, -300), pack(400, 700), 5, 0, 0).r2);

    // Three back-to-back inputs, then a 4-cycle stall on the first output.
    for (int i = 0; i < 3; i++) begin
      send(mid_val(), mid_val(), int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    wait_cnt = 0;
    while (!bus.out_valid && wait_cnt < 10) begin
      tick();
      wait_cnt++;
    end
    chk("t4_first_out", bus.out_valid, 1);
    bus.out_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_in_ready", bus.in_ready, 0);
      chk("t4_hold_valid", bus.out_valid, 1);
      chk("t4_hold_result1", bus.result1, q[0].r1);
      tick();
    end
    chk("t4_in_flight", q.size(), 3);
    drain("t4");

    // Reset with two transactions in flight.
    send(mid_val(), mid_val(), 1, 0, 0);
    tick();
    send(mid_val(), mid_val(), 6, 1, 1);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    sat_model = 1'b0;
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_in_ready", bus.in_ready, 1);
`ifdef BFLY_SAT_EN
    chk("t5_sat_flag", sat_flag, 0);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_stale", bus.out_valid, 0);
    end

`ifdef BFLY_SAT_EN
    run_one("t6_sat", pack(32767, 0), pack(32767, 0), 0, 0, 0, pack(32767, 0), pack(0, 0));
    chk("t6_sat_flag", sat_flag, 1);
`else
    run_one("t6_wrap", pack(32767, 0), pack(32767, 0), 0, 0, 0, pack(-2, 0), pack(0, 0));
`endif

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid      = ($urandom_range(0, 3) != 0);
      bus.num1          = ($urandom_range(0, 1) != 0) ? $urandom() : mid_val();
      bus.num2          = ($urandom_range(0, 1) != 0) ? $urandom() : mid_val();
      bus.twiddle_index = 3'($urandom_range(0, N - 1));
      bus.inverse       = 1'($urandom_range(0, 1));
      bus.scale         = 1'($urandom_range(0, 1));
      bus.out_ready     = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand");
`ifdef BFLY_SAT_EN
    chk("rand_sat_sticky", sat_flag, sat_model);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
